// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl
// ----------------------------------------------------------------------------
// Memory-stage controller for the 5-stage pipeline, between the X/M and M/W
// pipeline registers. It decodes the M-stage instruction into data-memory
// read/write strobes. A small IDLE/BUSY FSM stretches an access over MEM_LAT
// cycles and stalls the upstream stages while the access is in progress.
// Store data is forwarded from the current W-stage write, or from a short
// history of recent writebacks, and is held stable for the whole access.
//
// Parameters:
//   MEM_LAT      - data-memory latency in cycles (1..15); 1 = single-cycle
//   BYPASS_DEPTH - retired writebacks kept for store forwarding (1..4)
//   WORD_W       - data width
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   ir_m       in   M-stage instruction (opcode [31:27], rd [26:22])
//   valid_m    in   M-stage instruction is not a bubble
//   b_m        in   store data from the M-stage pipeline register
//   ir_w       in   W-stage instruction (rd [26:22])
//   wb_we      in   W stage writes the register file this cycle
//   wb_data    in   W-stage writeback value
//   mem_wren   out  data-memory write strobe
//   mem_rden   out  data-memory read strobe
//   stall      out  hold PC/F/D/X/M, bubble into W
//   store_data out  data presented to memory
//   byp_hit    out  store_data came from forwarding rather than b_m
//
// Optional feature (macro MEMCTRL_PERF_EN):
//   perf_mem_ops      out  saturating count of access starts
//   perf_stall_cycles out  saturating count of cycles with stall=1
// ============================================================================
module mem_stage_ctrl #(
    parameter int MEM_LAT      = 1,
    parameter int BYPASS_DEPTH = 2,
    parameter int WORD_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ir_m,
    input  logic              valid_m,
    input  logic [WORD_W-1:0] b_m,
    input  logic [31:0]       ir_w,
    input  logic              wb_we,
    input  logic [WORD_W-1:0] wb_data,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic              stall,
    output logic [WORD_W-1:0] store_data,
    output logic              byp_hit
`ifdef MEMCTRL_PERF_EN
    ,
    output logic [31:0]       perf_mem_ops,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam logic [4:0] OP_STORE = 5'b00111;
    localparam logic [4:0] OP_LOAD  = 5'b01000;
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
    localparam bit         MULTI    = (MEM_LAT > 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_hit_q, hold_hit_d;
    logic              hold_store_q, hold_store_d;

    logic [4:0]        opcode_m;
    logic [4:0]        rd_m;
    logic [4:0]        rd_w;
    logic              is_store;
    logic              is_load;
    logic              mem_op;
    logic              op_start;

    logic              fwd_hit;
    logic [WORD_W-1:0] fwd_data;

    logic              hist_valid_q [BYPASS_DEPTH];
    logic [4:0]        hist_rd_q    [BYPASS_DEPTH];
    logic [WORD_W-1:0] hist_data_q  [BYPASS_DEPTH];

    // Instruction fields that this stage never looks at.
    logic unused_bits;
    assign unused_bits = ^{ir_w[31:27], ir_w[21:0], ir_m[21:0]};

    assign opcode_m = ir_m[31:27];
    assign rd_m     = ir_m[26:22];
    assign rd_w     = ir_w[26:22];
    assign is_store = valid_m && (opcode_m == OP_STORE);
    assign is_load  = valid_m && (opcode_m == OP_LOAD);
    assign mem_op   = is_store || is_load;

    // Writeback history. Entry 0 is the write retired one cycle ago. It keeps
    // shifting during a stall because W receives bubbles, which simply push
    // invalid entries in. Writes to r0 are never recorded as valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BYPASS_DEPTH; i++) begin
                hist_valid_q[i] <= 1'b0;
            end
        end else begin
            hist_valid_q[0] <= wb_we && (rd_w != 5'd0);
            hist_rd_q[0]    <= rd_w;
            hist_data_q[0]  <= wb_data;
            for (int i = 1; i < BYPASS_DEPTH; i++) begin
                hist_valid_q[i] <= hist_valid_q[i-1];
                hist_rd_q[i]    <= hist_rd_q[i-1];
                hist_data_q[i]  <= hist_data_q[i-1];
            end
        end
    end

    // Store-data forwarding mux. The history is walked oldest to newest so
    // that the newest matching entry is the last assignment and wins; the
    // live W write overrides everything. r0 never matches.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = b_m;
        if (is_store && (rd_m != 5'd0)) begin
            if (wb_we && (rd_w == rd_m)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data;
            end else begin
                for (int i = BYPASS_DEPTH - 1; i >= 0; i--) begin
                    if (hist_valid_q[i] && (hist_rd_q[i] == rd_m)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = hist_data_q[i];
                    end
                end
            end
        end
    end

    // Access FSM state, cycle counter and the data/kind latched at the
    // start of a multi-cycle access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            hold_q       <= '0;
            hold_hit_q   <= 1'b0;
            hold_store_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_hit_q   <= hold_hit_d;
            hold_store_q <= hold_store_d;
        end
    end

    // Next-state and outputs. In IDLE the first cycle of an access is driven
    // straight from the inputs. In BUSY everything comes from the latched
    // copies, because W only carries bubbles by then and M must not be
    // trusted. Reset forces all outputs low in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_hit_d   = hold_hit_q;
        hold_store_d = hold_store_q;
        mem_wren     = 1'b0;
        mem_rden     = 1'b0;
        stall        = 1'b0;
        store_data   = fwd_data;
        byp_hit      = fwd_hit;
        op_start     = 1'b0;

        case (state_q)
            IDLE: begin
                mem_wren = is_store;
                mem_rden = is_load;
                op_start = mem_op;
                if (mem_op && MULTI) begin
                    stall        = 1'b1;
                    state_d      = BUSY;
                    cnt_d        = 4'd1;
                    hold_d       = fwd_data;
                    hold_hit_d   = fwd_hit;
                    hold_store_d = is_store;
                end
            end
            BUSY: begin
                mem_wren   = hold_store_q;
                mem_rden   = !hold_store_q;
                store_data = hold_q;
                byp_hit    = hold_hit_q;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            mem_wren   = 1'b0;
            mem_rden   = 1'b0;
            stall      = 1'b0;
            byp_hit    = 1'b0;
            store_data = '0;
            op_start   = 1'b0;
        end
    end

`ifdef MEMCTRL_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_mem_ops      <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (op_start && (perf_mem_ops != 32'hFFFF_FFFF)) begin
                perf_mem_ops <= perf_mem_ops + 32'd1;
            end
            if (stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`else
    // Without the counters the access-start pulse has no consumer.
    logic unused_op_start;
    assign unused_op_start = op_start;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// tb_mem_stage_ctrl
// ----------------------------------------------------------------------------
// Three instances of mem_stage_ctrl with different latency/history depth:
//   0: MEM_LAT=1, BYPASS_DEPTH=2
//   1: MEM_LAT=3, BYPASS_DEPTH=2
//   2: MEM_LAT=4, BYPASS_DEPTH=3
// Each instance has its own input set. Directed scenarios are followed by
// randomized traffic checked against a transaction-level model: a
// cycle-indexed log of writebacks for forwarding, and an "access in
// progress" position counter for the multi-cycle behaviour.
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int NDUT = 3;
    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_s    [NDUT];
    logic [31:0] ir_m       [NDUT];
    logic        valid_m    [NDUT];
    logic [31:0] b_m        [NDUT];
    logic [31:0] ir_w       [NDUT];
    logic        wb_we      [NDUT];
    logic [31:0] wb_data    [NDUT];
    logic        mem_wren   [NDUT];
    logic        mem_rden   [NDUT];
    logic        stall      [NDUT];
    logic [31:0] store_data [NDUT];
    logic        byp_hit    [NDUT];
`ifdef MEMCTRL_PERF_EN
    logic [31:0] perf_ops    [NDUT];
    logic [31:0] perf_stalls [NDUT];
`endif

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            mem_stage_ctrl #(
                .MEM_LAT      (g == 0 ? 1 : (g == 1 ? 3 : 4)),
                .BYPASS_DEPTH (g == 2 ? 3 : 2),
                .WORD_W       (32)
            ) u_dut (
                .clock      (clock),
                .reset      (reset_s[g]),
                .ir_m       (ir_m[g]),
                .valid_m    (valid_m[g]),
                .b_m        (b_m[g]),
                .ir_w       (ir_w[g]),
                .wb_we      (wb_we[g]),
                .wb_data    (wb_data[g]),
                .mem_wren   (mem_wren[g]),
                .mem_rden   (mem_rden[g]),
                .stall      (stall[g]),
                .store_data (store_data[g]),
                .byp_hit    (byp_hit[g])
`ifdef MEMCTRL_PERF_EN
                ,
                .perf_mem_ops      (perf_ops[g]),
                .perf_stall_cycles (perf_stalls[g])
`endif
            );
        end
    endgenerate

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    int last_rst [NDUT];
    logic        log_we   [NDUT][4096];
    logic [4:0]  log_rd   [NDUT][4096];
    logic [31:0] log_data [NDUT][4096];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h2A5A5};
    endfunction

    function automatic logic [35:0] obs(input int d);
        return {mem_wren[d], mem_rden[d], stall[d], byp_hit[d], store_data[d]};
    endfunction

    // Forwarding reference: a store to rd!=0 takes the live W write if it
    // matches, else the most recent logged write to rd retired 1..DEPTH
    // cycles ago (and after the last reset), else b_m.
    function automatic void model_fwd(input int d, output logic hit, output logic [31:0] val);
        logic [4:0] rd;
        int c;
        rd  = ir_m[d][26:22];
        hit = 1'b0;
        val = b_m[d];
        if (valid_m[d] && (ir_m[d][31:27] == OP_SW) && (rd != 5'd0)) begin
            if (wb_we[d] && (ir_w[d][26:22] == rd)) begin
                hit = 1'b1;
                val = wb_data[d];
            end else begin
                for (int k = 1; k <= depth_of(d); k++) begin
                    c = cyc - k;
                    if (!hit && (c > last_rst[d]) && (c >= 0) &&
                        log_we[d][c % 4096] && (log_rd[d][c % 4096] == rd)) begin
                        hit = 1'b1;
                        val = log_data[d][c % 4096];
                    end
                end
            end
        end
    endfunction

    // Log the W-stage inputs of every instance, advance one clock, and leave
    // time 1 unit past the rising edge for the next stimulus.
    task automatic tick();
        int idx;
        idx = cyc % 4096;
        for (int d = 0; d < NDUT; d++) begin
            log_we[d][idx]   = wb_we[d];
            log_rd[d][idx]   = ir_w[d][26:22];
            log_data[d][idx] = wb_data[d];
            if (reset_s[d]) last_rst[d] = cyc;
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic set_wb(input int d, input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we[d]   = we;
        ir_w[d]    = mk_ir(5'd0, rd);
        wb_data[d] = data;
    endtask

    task automatic set_m(input int d, input logic v, input logic [4:0] op, input logic [4:0] rd,
                         input logic [31:0] data);
        valid_m[d] = v;
        ir_m[d]    = mk_ir(op, rd);
        b_m[d]     = data;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            reset_s[d] = 1'b1;
            set_m(d, 1'b1, OP_SW, 5'd3, 32'hDEAD_0000 + d);
            set_wb(d, 1'b1, 5'd3, 32'hBEEF_0000 + d);
        end
        for (int n = 0; n < 2; n++) begin
            #3;
            for (int d = 0; d < NDUT; d++) begin
                total++;
                if (obs(d) !== 36'd0)
                    $display("[TB] FAIL reset_outputs dut%0d: got %h expected %h", d, obs(d), 36'd0);
                else passes++;
            end
            tick();
        end
        for (int d = 0; d < NDUT; d++) begin
            reset_s[d] = 1'b0;
            valid_m[d] = 1'b0;
            wb_we[d]   = 1'b0;
        end
        #3;
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (obs(d)[35:32] !== 4'd0)
                $display("[TB] FAIL reset_idle dut%0d: got %h expected %h", d, obs(d)[35:32], 4'd0);
            else passes++;
        end
        tick();
    endtask

    task automatic test_forwarding();
        // {name, expected} pairs checked one per scenario on the MEM_LAT=1 instance.
        set_m(0, 1'b1, OP_SW, 5'd5, 32'h11);
        set_wb(0, 1'b1, 5'd5, 32'h22);
        #3; total++;
        if (obs(0) !== {4'b1001, 32'h22})
            $display("[TB] FAIL fwd_w_stage: got %h expected %h", obs(0), {4'b1001, 32'h22});
        else passes++;
        tick();

        set_m(0, 1'b1, OP_SW, 5'd0, 32'h44);
        set_wb(0, 1'b1, 5'd0, 32'h33);
        #3; total++;
        if (obs(0) !== {4'b1000, 32'h44})
            $display("[TB] FAIL fwd_r0: got %h expected %h", obs(0), {4'b1000, 32'h44});
        else passes++;
        tick();

        set_m(0, 1'b0, OP_SW, 5'd9, 32'h0);
        set_wb(0, 1'b1, 5'd9, 32'h55);
        tick();
        set_wb(0, 1'b1, 5'd9, 32'h66);
        tick();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        set_m(0, 1'b1, OP_SW, 5'd9, 32'h77);
        #3; total++;
        if (obs(0) !== {4'b1001, 32'h66})
            $display("[TB] FAIL fwd_newest_hist: got %h expected %h", obs(0), {4'b1001, 32'h66});
        else passes++;
        tick();

        set_m(0, 1'b0, OP_SW, 5'd12, 32'h0);
        set_wb(0, 1'b1, 5'd12, 32'hC0);
        tick();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        tick();
        set_m(0, 1'b1, OP_SW, 5'd12, 32'h01);
        #3; total++;
        if (obs(0) !== {4'b1001, 32'hC0})
            $display("[TB] FAIL fwd_edge_k2: got %h expected %h", obs(0), {4'b1001, 32'hC0});
        else passes++;
        tick();

        set_m(0, 1'b0, OP_SW, 5'd10, 32'h0);
        set_wb(0, 1'b1, 5'd10, 32'h99);
        tick();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        set_m(0, 1'b1, OP_SW, 5'd10, 32'h02);
        #3; total++;
        if (obs(0) !== {4'b1000, 32'h02})
            $display("[TB] FAIL fwd_beyond_k3: got %h expected %h", obs(0), {4'b1000, 32'h02});
        else passes++;
        tick();

        set_m(0, 1'b0, OP_SW, 5'd11, 32'h0);
        set_wb(0, 1'b1, 5'd11, 32'hA1);
        tick();
        set_m(0, 1'b1, OP_SW, 5'd11, 32'h03);
        set_wb(0, 1'b1, 5'd11, 32'hA2);
        #3; total++;
        if (obs(0) !== {4'b1001, 32'hA2})
            $display("[TB] FAIL fwd_w_over_hist: got %h expected %h", obs(0), {4'b1001, 32'hA2});
        else passes++;
        tick();

        set_m(0, 1'b1, OP_LW, 5'd5, 32'h03);
        set_wb(0, 1'b1, 5'd5, 32'h04);
        #3; total++;
        if (obs(0) !== {4'b0100, 32'h03})
            $display("[TB] FAIL load_no_fwd: got %h expected %h", obs(0), {4'b0100, 32'h03});
        else passes++;
        tick();
        set_m(0, 1'b0, OP_SW, 5'd0, 32'h0);
        set_wb(0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_multicycle_store();
        logic [31:0] bseq [3];
        logic [2:0]  stl;
        bseq = '{32'h01, 32'h02, 32'h03};
        stl  = 3'b110;
        set_m(1, 1'b1, OP_SW, 5'd7, bseq[0]);
        set_wb(1, 1'b1, 5'd7, 32'hAB);
        for (int i = 0; i < 3; i++) begin
            b_m[1] = bseq[i];
            #3; total++;
            if (obs(1) !== {3'b101, 1'b1, 32'hAB} && (i < 2) || obs(1) !== {2'b10, stl[2-i], 1'b1, 32'hAB})
                $display("[TB] FAIL lat3_store c%0d: got %h expected %h", i, obs(1), {2'b10, stl[2-i], 1'b1, 32'hAB});
            else passes++;
            tick();
            set_wb(1, 1'b0, 5'd0, 32'h0);
        end
        valid_m[1] = 1'b0;
        #3; total++;
        if (obs(1)[35:32] !== 4'd0)
            $display("[TB] FAIL lat3_after: got %h expected %h", obs(1)[35:32], 4'd0);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bseq [6];
        logic [31:0] dexp [6];
        logic [5:0]  stl;
        bseq = '{32'h10, 32'h99, 32'h98, 32'h20, 32'h97, 32'h96};
        dexp = '{32'h10, 32'h10, 32'h10, 32'h20, 32'h20, 32'h20};
        stl  = 6'b110110;
        reset_s[1] = 1'b1;
        valid_m[1] = 1'b0;
        tick();
        reset_s[1] = 1'b0;
        set_m(1, 1'b1, OP_LW, 5'd3, 32'h10);
        for (int i = 0; i < 6; i++) begin
            b_m[1] = bseq[i];
            #3; total++;
            if (obs(1) !== {2'b01, stl[5-i], 1'b0, dexp[i]})
                $display("[TB] FAIL b2b_load c%0d: got %h expected %h", i, obs(1), {2'b01, stl[5-i], 1'b0, dexp[i]});
            else passes++;
            tick();
        end
        valid_m[1] = 1'b0;
        #3; total++;
        if (obs(1)[35:32] !== 4'd0)
            $display("[TB] FAIL b2b_after: got %h expected %h", obs(1)[35:32], 4'd0);
        else passes++;
`ifdef MEMCTRL_PERF_EN
        total++;
        if (perf_ops[1] !== 32'd2)
            $display("[TB] FAIL perf_mem_ops: got %0d expected %0d", perf_ops[1], 2);
        else passes++;
        total++;
        if (perf_stalls[1] !== 32'd4)
            $display("[TB] FAIL perf_stall_cycles: got %0d expected %0d", perf_stalls[1], 4);
        else passes++;
`endif
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] stl;
        stl = 4'b1110;
        set_m(2, 1'b1, OP_LW, 5'd2, 32'h05);
        #3; total++;
        if (obs(2) !== {4'b0110, 32'h05})
            $display("[TB] FAIL rstmid_c1: got %h expected %h", obs(2), {4'b0110, 32'h05});
        else passes++;
        tick();
        reset_s[2] = 1'b1;
        #3; total++;
        if (obs(2) !== 36'd0)
            $display("[TB] FAIL rstmid_c2: got %h expected %h", obs(2), 36'd0);
        else passes++;
        tick();
        reset_s[2] = 1'b0;
        valid_m[2] = 1'b0;
        #3; total++;
        if (obs(2)[35:32] !== 4'd0)
            $display("[TB] FAIL rstmid_idle: got %h expected %h", obs(2)[35:32], 4'd0);
        else passes++;
        tick();
        set_m(2, 1'b1, OP_LW, 5'd2, 32'h5A);
        for (int i = 0; i < 4; i++) begin
            #3; total++;
            if (obs(2) !== {2'b01, stl[3-i], 1'b0, 32'h5A})
                $display("[TB] FAIL rstmid_relw c%0d: got %h expected %h", i, obs(2), {2'b01, stl[3-i], 1'b0, 32'h5A});
            else passes++;
            tick();
        end
        valid_m[2] = 1'b0;
        #3; total++;
        if (obs(2)[35:32] !== 4'd0)
            $display("[TB] FAIL rstmid_done: got %h expected %h", obs(2)[35:32], 4'd0);
        else passes++;
        tick();
    endtask

    task automatic test_random(input int d, input int n);
        int          lat;
        int          pos;
        logic        active;
        logic        e_w, e_r, e_hit;
        logic [31:0] e_data;
        logic        is_sw, is_lw, rst;
        logic [4:0]  op;
        logic [35:0] exp_v;
        lat    = lat_of(d);
        active = 1'b0;
        pos    = 0;
        e_w = 1'b0; e_r = 1'b0; e_hit = 1'b0; e_data = '0;
        reset_s[d] = 1'b1;
        valid_m[d] = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            set_wb(d, 1'($urandom % 2), 5'($urandom_range(0, 3)), $urandom);
            b_m[d] = $urandom;
            if (!active) begin
                case ($urandom % 3)
                    0:       op = OP_SW;
                    1:       op = OP_LW;
                    default: op = 5'($urandom % 32);
                endcase
                valid_m[d] = ($urandom % 4) != 0;
                ir_m[d]    = mk_ir(op, 5'($urandom_range(0, 3)));
            end
            rst = ($urandom % 50) == 0;
            reset_s[d] = rst;
            #3;
            is_sw = valid_m[d] && (ir_m[d][31:27] == OP_SW);
            is_lw = valid_m[d] && (ir_m[d][31:27] == OP_LW);
            if (rst) begin
                active = 1'b0;
                total++;
                if (obs(d) !== 36'd0)
                    $display("[TB] FAIL rand%0d_reset i%0d: got %h expected %h", d, i, obs(d), 36'd0);
                else passes++;
            end else if (active) begin
                exp_v = {e_w, e_r, (pos < lat - 1), e_hit, e_data};
                total++;
                if (obs(d) !== exp_v)
                    $display("[TB] FAIL rand%0d_busy i%0d: got %h expected %h", d, i, obs(d), exp_v);
                else passes++;
                pos++;
                if (pos == lat) active = 1'b0;
            end else if (is_sw || is_lw) begin
                model_fwd(d, e_hit, e_data);
                e_w   = is_sw;
                e_r   = is_lw;
                exp_v = {e_w, e_r, (lat > 1), e_hit, e_data};
                total++;
                if (obs(d) !== exp_v)
                    $display("[TB] FAIL rand%0d_start i%0d: got %h expected %h", d, i, obs(d), exp_v);
                else passes++;
                if (lat > 1) begin
                    active = 1'b1;
                    pos    = 1;
                end
            end else begin
                total++;
                if (obs(d)[35:32] !== 4'd0)
                    $display("[TB] FAIL rand%0d_idle i%0d: got %h expected %h", d, i, obs(d)[35:32], 4'd0);
                else passes++;
            end
            tick();
        end
        reset_s[d] = 1'b0;
        valid_m[d] = 1'b0;
        wb_we[d]   = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            reset_s[d] = 1'b1;
            set_m(d, 1'b0, 5'd0, 5'd0, 32'h0);
            set_wb(d, 1'b0, 5'd0, 32'h0);
            last_rst[d] = 0;
        end
        test_reset();
        test_forwarding();
        test_multicycle_store();
        test_back_to_back();
        test_reset_mid_access();
        for (int d = 0; d < NDUT; d++) begin
            test_random(d, 300);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised memory-stage controller for the 5-stage pipeline, sitting between the X/M and M/W pipeline registers. It decodes the M-stage instruction into data-memory read/write strobes and runs a multi-cycle access FSM that stalls upstream stages for memories slower than one cycle. It also forwards store data from the W-stage write and from a short history of recent writebacks, and holds that data stable across the access. This generalises the single-cycle store-enable / single-compare bypass logic.

## Interface
- MEM_LAT, 1: data-memory access latency in cycles (1..15); 1 means single-cycle, with no FSM stall.
- BYPASS_DEPTH, 2: number of retired writebacks kept for store-data forwarding (1..4).
- WORD_W, 32: data width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ir_m  in  32  M-stage instruction; opcode [31:27], rd [26:22].
- valid_m  in  1  M-stage instruction is not a bubble.
- b_m  in  WORD_W  store data from the M-stage pipeline register.
- ir_w  in  32  W-stage instruction; rd [26:22].
- wb_we  in  1  W stage writes the register file this cycle.
- wb_data  in  WORD_W  W-stage writeback value.
- mem_wren  out  1  data-memory write strobe.
- mem_rden  out  1  data-memory read strobe.
- stall  out  1  hold PC, F, D, X and M; bubble into W.
- store_data  out  WORD_W  data presented to memory.
- byp_hit  out  1  store_data came from forwarding rather than b_m.

## Operation
- Decode: store = valid_m & opcode 00111; load = valid_m & opcode 01000; mem_op = store | load.
- Forwarding applies to stores only. The compared register is ir_m[26:22].
  - Priority 1: current W write (wb_we, ir_w[26:22] matches).
  - Priority 2: history entries, newest first.
  - Otherwise use b_m.
  - Register 0 never matches, at any level.
- History: a shift register of BYPASS_DEPTH entries {valid, rd, data}. It shifts every cycle and is not frozen by stall. The new entry is valid only when wb_we=1 and rd≠0.
- FSM states are IDLE and BUSY, with a cycle counter cnt of 4 bits.
  - IDLE, when mem_op and MEM_LAT>1: go to BUSY, set cnt=1, latch the forwarded store data into hold_q.
  - BUSY: cnt increments each cycle. The cycle in which cnt==MEM_LAT-1 is the completion cycle; the next state is IDLE.
  - If MEM_LAT==1 the FSM never leaves IDLE.
- stall = mem_op in IDLE when MEM_LAT>1, or in BUSY before the completion cycle. stall is low in the completion cycle.
- mem_wren and mem_rden are held high for all MEM_LAT cycles of the operation.
- store_data:
  - First cycle of the operation: the forwarding-mux output.
  - BUSY cycles: hold_q, since W holds bubbles during the stall and the original source is gone.
  - byp_hit is latched alongside hold_q.
- valid_m or ir_m changing while in BUSY is a protocol violation. The access completes regardless.
- Back-to-back memory ops: after a completion cycle, a new mem_op in the next cycle starts a fresh access from IDLE.

## Timing
- Reset (synchronous, active-high):
  - Next edge: state=IDLE, cnt=0, hold_q=0, latched byp_hit=0, all history entries invalid.
  - While reset=1: mem_wren, mem_rden, stall and byp_hit are forced to 0, and store_data=0.
- Reset mid-access aborts the operation. stall is low from the cycle reset is sampled, and no completion cycle occurs.
- Latency:
  - MEM_LAT==1: strobes and store_data are combinational from the inputs, with zero stall.
  - MEM_LAT=N: the operation occupies exactly N cycles, with stall high for the first N-1.
- History hit window: a write retired k cycles ago is visible for 1 ≤ k ≤ BYPASS_DEPTH.

## Configuration
- MEMCTRL_PERF_EN defined: adds two outputs.
  - perf_mem_ops [31:0]: counts operation starts.
  - perf_stall_cycles [31:0]: counts cycles with stall=1.
  - Both are saturating at all-ones and cleared by reset.
- MEMCTRL_PERF_EN not defined: neither the ports nor the counters exist, and behaviour is otherwise identical.

## Test plan
- MEM_LAT=1, sw r5 in M with b_m=0x11, and W writing r5=0x22 → mem_wren=1, store_data=0x22, byp_hit=1, stall=0.
- MEM_LAT=1, sw r0 in M with W writing r0=0x33 → store_data=b_m, byp_hit=0.
- MEM_LAT=3, sw r7 in M, W writes r7=0xAB in cycle 1 only → stall=1,1,0; mem_wren=1,1,1; store_data=0xAB in all three cycles.
- BYPASS_DEPTH=2, r9=0x55 written 2 cycles earlier and r9=0x66 written 1 cycle earlier, then sw r9 → store_data=0x66, byp_hit=1.
- MEM_LAT=4, lw, reset asserted in cycle 2 → stall=0 and mem_rden=0 from cycle 2, FSM in IDLE, then a lw after reset deasserts completes normally in 4 cycles.
- MEMCTRL_PERF_EN defined, two back-to-back lw with MEM_LAT=3 → perf_mem_ops=2, perf_stall_cycles=4.
